// File: rtl/scmp_pkg.sv
// Shared types and constants for the SC/MP memory arbiter and its helpers.
package scmp_pkg;
  localparam int SCMP_DATA_W = 8;
  localparam int WAIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;
endpackage

// File: rtl/scmp_mem_arb_if.sv
// Two-master memory sharing bus: SC/MP port 0, loader port 1, memory macro side.
interface scmp_mem_arb_if
  import scmp_pkg::*;
#(
  parameter int C_SIZE = 16
);
  logic                   m0_req, m0_we, m0_ack;
  logic [C_SIZE-1:0]      m0_addr;
  logic [SCMP_DATA_W-1:0] m0_wdata, m0_rdata;
  logic                   m1_req, m1_we, m1_ack;
  logic [C_SIZE-1:0]      m1_addr;
  logic [SCMP_DATA_W-1:0] m1_wdata, m1_rdata;
  logic                   mem_ce, mem_we;
  logic [C_SIZE-1:0]      mem_addr;
  logic [SCMP_DATA_W-1:0] mem_wdata, mem_rdata;
  logic                   busy, owner;

  // Arbiter view.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_ce, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  // Masters plus memory macro view.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_ce, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/scmp_rr_arb2.sv
// Combinational 2-way round-robin grant: on a tie the port that did not
// hold the last grant wins.
module scmp_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       owner_i,
  output logic       gnt_vld_o,
  output logic       gnt_port_o
);
  always_comb begin
    gnt_vld_o  = |req_i;
    gnt_port_o = (&req_i) ? ~owner_i : req_i[1];
  end
endmodule

// File: rtl/scmp_mem_arb.sv
// Shares one 8-bit SRAM between the SC/MP bus and the loader, one access at a
// time with WAIT_STATES extra cycles; every output comes straight from a flop.
module scmp_mem_arb
  import scmp_pkg::*;
#(
  parameter int C_SIZE      = 16,
  parameter int WAIT_STATES = 2,
  parameter bit SIM         = 1'b0
) (
  input  logic           clk_50m,
  input  logic           rst,
  scmp_mem_arb_if.slave  bus
);
  if (SIM && (WAIT_STATES < 0 || WAIT_STATES > 15)) begin : g_bad_ws
    $error("scmp_mem_arb: WAIT_STATES=%0d outside 0..15", WAIT_STATES);
  end

  localparam logic [WAIT_CNT_W-1:0] WS_INIT = WAIT_CNT_W'(WAIT_STATES);

  arb_state_t                       state_q, state_d;
  logic [WAIT_CNT_W-1:0]            cnt_q, cnt_d;
  logic                             owner_q, owner_d;
  logic                             busy_q, busy_d;
  logic                             ce_q, ce_d;
  logic                             we_q, we_d;
  logic [C_SIZE-1:0]                addr_q, addr_d;
  logic [SCMP_DATA_W-1:0]           wdata_q, wdata_d;
  logic [1:0]                       ack_q, ack_d;
  logic [1:0][SCMP_DATA_W-1:0]      rdata_q, rdata_d;
  logic                             gnt_vld, gnt_port;

  scmp_rr_arb2 u_rr (
    .req_i      ({bus.m1_req, bus.m0_req}),
    .owner_i    (owner_q),
    .gnt_vld_o  (gnt_vld),
    .gnt_port_o (gnt_port)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ce_d    = ce_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_port;
          ce_d    = 1'b1;
          cnt_d   = WS_INIT;
          state_d = ACCESS;
          if (gnt_port) begin
            addr_d  = bus.m1_addr;
            we_d    = bus.m1_we;
            wdata_d = bus.m1_wdata;
          end else begin
            addr_d  = bus.m0_addr;
            we_d    = bus.m0_we;
            wdata_d = bus.m0_wdata;
          end
        end
      end
      ACCESS: begin
        // owner_q names the port being served for the whole access.
        if (cnt_q == '0) begin
          ce_d           = 1'b0;
          we_d           = 1'b0;
          ack_d[owner_q] = 1'b1;
          if (!we_q) rdata_d[owner_q] = bus.mem_rdata;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b1;
      busy_q  <= 1'b0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.mem_ce    = ce_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.m0_ack    = ack_q[0];
  assign bus.m1_ack    = ack_q[1];
  assign bus.m0_rdata  = rdata_q[0];
  assign bus.m1_rdata  = rdata_q[1];
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
endmodule

// File: tb/tb_scmp_mem_arb.sv
// Bench for scmp_mem_arb: directed cycle table, WAIT_STATES=0 sequence and a
// randomized run against an interval-based transaction model.
module tb_scmp_mem_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scmp_mem_arb_if #(.C_SIZE(9)) b2 ();
  scmp_mem_arb_if #(.C_SIZE(9)) b0 ();

  scmp_mem_arb #(.C_SIZE(9), .WAIT_STATES(2), .SIM(1'b1)) u_dut2 (
    .clk_50m (clk), .rst (rst), .bus (b2.slave));
  scmp_mem_arb #(.C_SIZE(9), .WAIT_STATES(0), .SIM(1'b1)) u_dut0 (
    .clk_50m (clk), .rst (rst), .bus (b0.slave));

  // Memory macros: combinational read, write on the clock edge, preloaded in reset.
  logic [7:0] mem2 [512];
  logic [7:0] mem0 [512];
  assign b2.mem_rdata = mem2[b2.mem_addr];
  assign b0.mem_rdata = mem0[b0.mem_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) begin
        mem2[i] <= 8'(i) ^ 8'h5A;
        mem0[i] <= 8'(i) ^ 8'hC3;
      end
      mem2[9'h123] <= 8'hA5;
      mem0[9'h055] <= 8'h77;
    end else begin
      if (b2.mem_ce && b2.mem_we) mem2[b2.mem_addr] <= b2.mem_wdata;
      if (b0.mem_ce && b0.mem_we) mem0[b0.mem_addr] <= b0.mem_wdata;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(logic ce, logic we, logic busy, logic own,
                                     logic [1:0] ack, logic [8:0] maddr,
                                     logic [7:0] mwd, logic [7:0] rd0, logic [7:0] rd1);
    return {25'b0, ce, we, busy, own, ack, maddr, mwd, rd0, rd1};
  endfunction

  function automatic logic [63:0] act2();
    return pk(b2.mem_ce, b2.mem_we, b2.busy, b2.owner, {b2.m1_ack, b2.m0_ack},
              b2.mem_addr, b2.mem_wdata, b2.m0_rdata, b2.m1_rdata);
  endfunction

  typedef struct {
    logic       rst;
    logic [1:0] req, we;
    logic [8:0] addr;
    logic [7:0] wd;
    logic [63:0] exp;
  } vec_t;

  function automatic vec_t mk(logic r, logic [1:0] req, logic [1:0] we, logic [8:0] addr,
                              logic [7:0] wd, logic ce, logic mwe, logic busy, logic own,
                              logic [1:0] ack, logic [8:0] maddr, logic [7:0] mwd,
                              logic [7:0] rd0, logic [7:0] rd1);
    vec_t v;
    v.rst = r; v.req = req; v.we = we; v.addr = addr; v.wd = wd;
    v.exp = pk(ce, mwe, busy, own, ack, maddr, mwd, rd0, rd1);
    return v;
  endfunction

  task automatic drive2(input logic [1:0] req, input logic [1:0] we,
                        input logic [8:0] a0, input logic [8:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1);
    b2.m0_req = req[0]; b2.m0_we = we[0]; b2.m0_addr = a0; b2.m0_wdata = d0;
    b2.m1_req = req[1]; b2.m1_we = we[1]; b2.m1_addr = a1; b2.m1_wdata = d1;
  endtask

  vec_t       tbl [29];
  logic [7:0] ref_mem [512];
  logic [1:0] rq, rwe;
  logic [8:0] radr [2];
  logic [7:0] rwd [2];
  logic [7:0] exp_rd [2];
  bit         pend [2];
  bit         acc, ackn, have, gwe, exp_own;
  int         g, gp, idle_at;
  logic [7:0] grd, exp_mwd;
  logic [8:0] exp_maddr;
  localparam int W = 2;

  initial begin
    //           rst req   we    addr    wd   | ce mwe bsy own ack  maddr   mwd   rd0   rd1
    tbl[0]  = mk(0, 2'b01, 2'b00, 9'h123, 8'h00, 0, 0, 0, 1, 2'b00, 9'h000, 8'h00, 8'h00, 8'h00);
    tbl[1]  = mk(0, 2'b01, 2'b00, 9'h123, 8'h00, 1, 0, 1, 0, 2'b00, 9'h123, 8'h00, 8'h00, 8'h00);
    tbl[2]  = mk(0, 2'b01, 2'b00, 9'h123, 8'h00, 1, 0, 1, 0, 2'b00, 9'h123, 8'h00, 8'h00, 8'h00);
    tbl[3]  = mk(0, 2'b01, 2'b00, 9'h123, 8'h00, 1, 0, 1, 0, 2'b00, 9'h123, 8'h00, 8'h00, 8'h00);
    tbl[4]  = mk(0, 2'b00, 2'b00, 9'h000, 8'h00, 0, 0, 1, 0, 2'b01, 9'h123, 8'h00, 8'hA5, 8'h00);
    tbl[5]  = mk(0, 2'b10, 2'b10, 9'h010, 8'h3C, 0, 0, 0, 0, 2'b00, 9'h123, 8'h00, 8'hA5, 8'h00);
    tbl[6]  = mk(0, 2'b10, 2'b10, 9'h010, 8'h3C, 1, 1, 1, 1, 2'b00, 9'h010, 8'h3C, 8'hA5, 8'h00);
    tbl[7]  = mk(0, 2'b10, 2'b10, 9'h010, 8'h3C, 1, 1, 1, 1, 2'b00, 9'h010, 8'h3C, 8'hA5, 8'h00);
    tbl[8]  = mk(0, 2'b10, 2'b10, 9'h010, 8'h3C, 1, 1, 1, 1, 2'b00, 9'h010, 8'h3C, 8'hA5, 8'h00);
    tbl[9]  = mk(0, 2'b00, 2'b00, 9'h000, 8'h00, 0, 0, 1, 1, 2'b10, 9'h010, 8'h3C, 8'hA5, 8'h00);
    tbl[10] = mk(0, 2'b01, 2'b00, 9'h010, 8'h00, 0, 0, 0, 1, 2'b00, 9'h010, 8'h3C, 8'hA5, 8'h00);
    tbl[11] = mk(0, 2'b01, 2'b00, 9'h010, 8'h00, 1, 0, 1, 0, 2'b00, 9'h010, 8'h00, 8'hA5, 8'h00);
    tbl[12] = mk(0, 2'b01, 2'b00, 9'h010, 8'h00, 1, 0, 1, 0, 2'b00, 9'h010, 8'h00, 8'hA5, 8'h00);
    tbl[13] = mk(0, 2'b01, 2'b00, 9'h010, 8'h00, 1, 0, 1, 0, 2'b00, 9'h010, 8'h00, 8'hA5, 8'h00);
    tbl[14] = mk(0, 2'b00, 2'b00, 9'h000, 8'h00, 0, 0, 1, 0, 2'b01, 9'h010, 8'h00, 8'h3C, 8'h00);
    tbl[15] = mk(0, 2'b01, 2'b00, 9'h123, 8'h00, 0, 0, 0, 0, 2'b00, 9'h010, 8'h00, 8'h3C, 8'h00);
    tbl[16] = mk(0, 2'b01, 2'b00, 9'h123, 8'h00, 1, 0, 1, 0, 2'b00, 9'h123, 8'h00, 8'h3C, 8'h00);
    tbl[17] = mk(1, 2'b01, 2'b00, 9'h123, 8'h00, 1, 0, 1, 0, 2'b00, 9'h123, 8'h00, 8'h3C, 8'h00);
    tbl[18] = mk(0, 2'b11, 2'b00, 9'h123, 8'h00, 0, 0, 0, 1, 2'b00, 9'h000, 8'h00, 8'h00, 8'h00);
    tbl[19] = mk(0, 2'b11, 2'b00, 9'h123, 8'h00, 1, 0, 1, 0, 2'b00, 9'h123, 8'h00, 8'h00, 8'h00);
    tbl[20] = mk(0, 2'b11, 2'b00, 9'h123, 8'h00, 1, 0, 1, 0, 2'b00, 9'h123, 8'h00, 8'h00, 8'h00);
    tbl[21] = mk(0, 2'b11, 2'b00, 9'h123, 8'h00, 1, 0, 1, 0, 2'b00, 9'h123, 8'h00, 8'h00, 8'h00);
    tbl[22] = mk(0, 2'b10, 2'b00, 9'h123, 8'h00, 0, 0, 1, 0, 2'b01, 9'h123, 8'h00, 8'hA5, 8'h00);
    tbl[23] = mk(0, 2'b10, 2'b00, 9'h123, 8'h00, 0, 0, 0, 0, 2'b00, 9'h123, 8'h00, 8'hA5, 8'h00);
    tbl[24] = mk(0, 2'b10, 2'b00, 9'h123, 8'h00, 1, 0, 1, 1, 2'b00, 9'h123, 8'h00, 8'hA5, 8'h00);
    tbl[25] = mk(0, 2'b10, 2'b00, 9'h123, 8'h00, 1, 0, 1, 1, 2'b00, 9'h123, 8'h00, 8'hA5, 8'h00);
    tbl[26] = mk(0, 2'b10, 2'b00, 9'h123, 8'h00, 1, 0, 1, 1, 2'b00, 9'h123, 8'h00, 8'hA5, 8'h00);
    tbl[27] = mk(0, 2'b00, 2'b00, 9'h000, 8'h00, 0, 0, 1, 1, 2'b10, 9'h123, 8'h00, 8'hA5, 8'hA5);
    tbl[28] = mk(0, 2'b00, 2'b00, 9'h000, 8'h00, 0, 0, 0, 1, 2'b00, 9'h123, 8'h00, 8'hA5, 8'hA5);

    drive2(2'b00, 2'b00, '0, '0, '0, '0);
    b0.m0_req = 0; b0.m0_we = 0; b0.m0_addr = '0; b0.m0_wdata = '0;
    b0.m1_req = 0; b0.m1_we = 0; b0.m1_addr = '0; b0.m1_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // Directed cycle table on the WAIT_STATES=2 instance.
    for (int i = 0; i < 29; i++) begin
      @(posedge clk); #1;
      chk("table", i, act2(), tbl[i].exp);
      rst = tbl[i].rst;
      drive2(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].addr, tbl[i].wd, tbl[i].wd);
    end

    // WAIT_STATES=0: m1 holds req, so one read completes every 3 cycles.
    for (int c = 0; c < 13; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      chk("ws0", c,
          {57'b0, b0.mem_ce, b0.mem_we, b0.busy, b0.owner, b0.m1_ack, b0.m0_ack, 1'b0},
          {57'b0, 1'(c % 3 == 1), 1'b0, 1'(c % 3 != 0), 1'b1, 1'(c % 3 == 2), 1'b0, 1'b0});
      if (c >= 2) chk("ws0_rd", c, 64'(b0.m1_rdata), 64'h77);
      if (c == 0) begin
        b0.m1_req = 1'b1; b0.m1_we = 1'b0; b0.m1_addr = 9'h055;
      end
    end
    b0.m1_req = 1'b0;

    // Randomized traffic on the WAIT_STATES=2 instance vs. an interval model.
    for (int i = 0; i < 512; i++) ref_mem[i] = mem2[i];
    exp_rd[0] = 8'hA5; exp_rd[1] = 8'hA5;
    exp_own = 1'b1; exp_maddr = 9'h123; exp_mwd = 8'h00;
    have = 0; g = -100; gp = 0; gwe = 0; grd = '0; idle_at = 0;
    pend[0] = 0; pend[1] = 0; rq = '0; rwe = '0;
    for (int p = 0; p < 2; p++) begin radr[p] = '0; rwd[p] = '0; end
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      acc  = have && (c >= g + 1) && (c <= g + W + 1);
      ackn = have && (c == g + W + 2);
      if (ackn && !gwe) exp_rd[gp] = grd;
      chk("rand", c, act2(),
          pk(acc, acc && gwe, acc || ackn, exp_own,
             {ackn && gp == 1, ackn && gp == 0}, exp_maddr, exp_mwd, exp_rd[0], exp_rd[1]));
      for (int p = 0; p < 2; p++) begin
        if (ackn && gp == p) pend[p] = 0;
        if (acc && gp == p) begin
          // Served master scrambles its lines; the access must be unaffected.
          rq[p] = 1'($urandom_range(0, 1)); rwe[p] = 1'($urandom_range(0, 1));
          radr[p] = 9'($urandom_range(0, 511)); rwd[p] = 8'($urandom);
        end else if (!pend[p]) begin
          if ($urandom_range(0, 9) < 6) begin
            pend[p] = 1; rq[p] = 1'b1; rwe[p] = 1'($urandom_range(0, 1));
            radr[p] = 9'($urandom_range(0, 15)); rwd[p] = 8'($urandom);
          end else begin
            rq[p] = 1'b0;
          end
        end
      end
      drive2(rq, rwe, radr[0], radr[1], rwd[0], rwd[1]);
      if (c >= idle_at && rq != 2'b00) begin
        gp = (rq == 2'b11) ? int'(!exp_own) : int'(rq[1]);
        g = c; have = 1; idle_at = c + W + 3;
        exp_own = 1'(gp); gwe = rwe[gp];
        exp_maddr = radr[gp]; exp_mwd = rwd[gp];
        if (gwe) ref_mem[radr[gp]] = rwd[gp];
        else grd = ref_mem[radr[gp]];
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
